// File: rtl/adder_pkg.sv
// Shared definitions for the nibble accumulator and its 4-bit adder.
// Holds the accumulator FSM encoding and the operand width.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

endpackage

// File: rtl/Adder_4bit.sv
// Purely combinational 4-bit ripple-carry adder with no carry-in.
// Each bit is a full adder fed by the carry of the bit below it.
module Adder_4bit
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    output logic [NIBBLE_W-1:0] Sum,
    output logic                Cout
);

    logic [NIBBLE_W:0] carry;

    always_comb begin
        carry = '0;
        Sum   = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            Sum[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        Cout = carry[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_accumulator.sv
// Sums a burst of N_OPS nibbles through Adder_4bit, counting carry-outs to
// widen the total, and hands the result off on a valid/ready handshake.
module nibble_accumulator
    import adder_pkg::*;
#(
    parameter  int N_OPS   = 4,
    localparam int CARRY_W = $clog2(N_OPS),
    localparam int RES_W   = NIBBLE_W + CARRY_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [NIBBLE_W-1:0] in_data,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    result,
    output logic                busy
);

    acc_state_t           state;
    acc_state_t           state_next;
    logic [NIBBLE_W-1:0]  acc;
    logic [CARRY_W-1:0]   carry_cnt;
    logic [CARRY_W-1:0]   op_cnt;
    logic [NIBBLE_W-1:0]  sum;
    logic                 cout;
    logic                 accept;
    logic                 last_op;

    Adder_4bit u_adder (
        .A    (acc),
        .B    (in_data),
        .Sum  (sum),
        .Cout (cout)
    );

    assign accept  = in_valid && in_ready;
    assign last_op = (op_cnt == CARRY_W'(N_OPS - 1));
    assign result  = {carry_cnt, acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACC;
            ACC:     if (accept && last_op) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // The sum registers keep their value through IDLE so the last result
    // remains readable until the next start clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            carry_cnt <= '0;
            op_cnt    <= '0;
        end else if (state == IDLE && start) begin
            acc       <= '0;
            carry_cnt <= '0;
            op_cnt    <= '0;
        end else if (accept) begin
            acc       <= sum;
            carry_cnt <= carry_cnt + CARRY_W'(cout);
            op_cnt    <= op_cnt + CARRY_W'(1);
        end
    end

endmodule

// File: tb/tb_nibble_accumulator.sv
// Self-checking bench for nibble_accumulator with N_OPS=4: directed bursts
// plus random bursts, each compared against the arithmetic sum of its operands.
module tb_nibble_accumulator;

    localparam int N_OPS = 4;
    localparam int RES_W = 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [3:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] result;
    logic             busy;

    int total;
    int bad;
    logic [3:0] ops [N_OPS];

    nibble_accumulator #(.N_OPS(N_OPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One full burst of ops[], optionally with an input gap before operand
    // gap_at, a consumer stall in DONE, and stray start pulses along the way.
    task automatic applyStimulus(input int gap_at, input int gap_len,
                                 input int stall_len, input bit poke_start);
        int expected;
        expected = 0;
        foreach (ops[i]) expected += int'(ops[i]);

        out_ready = (stall_len == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("acc_busy", int'(busy), 1);
        checkOutput("acc_in_ready", int'(in_ready), 1);

        for (int i = 0; i < N_OPS; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0;
                    in_data  = 4'hF;
                    start    = poke_start;
                    tick();
                    start = 1'b0;
                    checkOutput("gap_in_ready", int'(in_ready), 1);
                    checkOutput("gap_out_valid", int'(out_valid), 0);
                end
            end
            in_valid = 1'b1;
            in_data  = ops[i];
            tick();
        end

        in_data = 4'hF;
        checkOutput("done_out_valid", int'(out_valid), 1);
        checkOutput("done_result", int'(result), expected);
        checkOutput("done_in_ready", int'(in_ready), 0);

        for (int s = 0; s < stall_len; s++) begin
            start = poke_start;
            tick();
            start = 1'b0;
            checkOutput("stall_out_valid", int'(out_valid), 1);
            checkOutput("stall_result", int'(result), expected);
            checkOutput("stall_busy", int'(busy), 1);
        end

        out_ready = 1'b1;
        start     = poke_start;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("idle_out_valid", int'(out_valid), 0);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_result_held", int'(result), expected);

        tick();
        checkOutput("idle_stays", int'(busy), 0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_in_ready", int'(in_ready), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_result", int'(result), 0);
        checkOutput("reset_busy", int'(busy), 0);

        in_valid = 1'b1;
        in_data  = 4'hF;
        tick();
        tick();
        in_valid = 1'b0;
        checkOutput("idle_drop_in_ready", int'(in_ready), 0);
        checkOutput("idle_drop_result", int'(result), 0);
        checkOutput("idle_drop_busy", int'(busy), 0);

        ops = '{4'h3, 4'h5, 4'h7, 4'h9};
        applyStimulus(-1, 0, 0, 1'b0);

        ops = '{4'hF, 4'hF, 4'hF, 4'hF};
        applyStimulus(-1, 0, 0, 1'b0);
        checkOutput("all_f_literal", int'(result), 'h3C);

        ops = '{4'h3, 4'h5, 4'h7, 4'h9};
        applyStimulus(2, 3, 0, 1'b1);
        checkOutput("gap_literal", int'(result), 'h18);

        applyStimulus(-1, 0, 5, 1'b1);

        // Abort a burst after two operands; everything must clear at once.
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'h3;
        tick();
        in_data = 4'h5;
        tick();
        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("abort_result", int'(result), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_in_ready", int'(in_ready), 0);
        checkOutput("abort_out_valid", int'(out_valid), 0);

        ops = '{4'h1, 4'h1, 4'h1, 4'h1};
        applyStimulus(-1, 0, 0, 1'b0);
        checkOutput("ones_literal", int'(result), 'h04);

        ops = '{4'h0, 4'h0, 4'h0, 4'h0};
        applyStimulus(-1, 0, 2, 1'b0);

        for (int r = 0; r < 12; r++) begin
            foreach (ops[i]) ops[i] = 4'($urandom_range(0, 15));
            applyStimulus(int'($urandom_range(0, N_OPS - 1)),
                          int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end

        $display("[TB] directed and random bursts complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_accumulator.md
Name: nibble_accumulator

Overview:
- Sequential stage that wraps the team's existing 4-bit ripple adder (`Adder_4bit`, no carry-in).
- Accepts a burst of N_OPS 4-bit operands over a valid/ready handshake.
- Each accepted operand is added into a 4-bit running sum. Each adder carry-out is counted, which widens the sum.
- Presents the full-width total on an output valid/ready handshake. Sits directly downstream of the operand source and upstream of any consumer of the total.

Parameters:
- N_OPS, 4, number of operands per burst; legal range 2..16.
- CARRY_W, $clog2(N_OPS), width of the carry counter. Derived; do not override.
- RES_W, 4+CARRY_W, width of the result.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a burst; honoured only in IDLE.
- in_valid  in  1  operand valid.
- in_data  in  4  operand nibble.
- in_ready  out  1  stage can accept an operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  RES_W  {carry_cnt, acc}.
- busy  out  1  high in ACC or DONE.

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high, sampled on the rising edge of clk.
- Reset state: IDLE, acc=0, carry_cnt=0, op_cnt=0. Outputs: in_ready=0, out_valid=0, result=0, busy=0.
- FSM has three states: IDLE, ACC and DONE.
- IDLE:
  - in_ready=0 and out_valid=0.
  - On start=1: clear acc, carry_cnt and op_cnt, then go to ACC next cycle.
- ACC:
  - in_ready=1 and out_valid=0.
  - Accept occurs when in_valid && in_ready at a clock edge. On accept: acc<=adder Sum(acc,in_data); carry_cnt<=carry_cnt+Cout; op_cnt<=op_cnt+1.
  - If in_valid=0 in a cycle, all registers hold. Gaps of any length are legal.
  - An accept with op_cnt==N_OPS-1 moves the FSM to DONE.
- DONE:
  - in_ready=0 and out_valid=1.
  - result is stable and equals the exact sum of the N_OPS operands.
  - On out_ready=1: go to IDLE. result keeps its last value in IDLE until the next start clears it.
  - out_valid holds until out_ready arrives; the consumer may stall indefinitely.
- Latency: out_valid rises on the cycle after the last accept.
- Minimum burst time is N_OPS+2 cycles from the start pulse to the return to IDLE, when in_valid and out_ready are held high.
- Width rules:
  - acc wraps modulo 16.
  - carry_cnt never overflows: the worst case is N_OPS*15 < 16*N_OPS, so at most N_OPS-1 carries.
- Boundary conditions:
  - start in ACC or DONE is ignored. It does not restart or corrupt the burst.
  - in_valid while in IDLE or DONE: the operand is not accepted (in_ready=0) and is dropped by protocol.
  - start and out_ready in the same DONE cycle: out_ready is honoured and start is ignored. A new start is needed in IDLE.
  - rst mid-burst (any state): next cycle the block is in IDLE with all registers zero and the partial sum discarded.
  - rst has priority over start, in_valid and out_ready.
- The adder is purely combinational. The only registers are acc, carry_cnt, op_cnt and the state.

Decomposition:
- Shared package `adder_pkg` holds:
  - the typedef enum logic [1:0] {IDLE, ACC, DONE} for the accumulator state;
  - localparam NIBBLE_W=4.
- One sub-module: `Adder_4bit`, instantiated once. Its A input is acc, B is in_data, Sum feeds acc next-state, Cout feeds the carry_cnt increment.
- No further hierarchy.

Test Plan (N_OPS=4, RES_W=6):
- Reset, then start, then operands 3,5,7,9 with in_valid held high and out_ready=1 → out_valid one cycle after the 4th accept with result=6'h18 (24, carry_cnt=1); IDLE on the next cycle.
- Operands F,F,F,F → result=6'h3C (carry_cnt=3, acc=C), confirming carry accumulation on consecutive carries.
- Same burst with in_valid deasserted for 3 cycles between operands 2 and 3 → result unchanged (6'h18); in_ready stays 1 throughout ACC.
- out_ready held low for 5 cycles in DONE → out_valid and result stay constant. A start pulse during DONE is ignored and busy stays 1. The FSM returns to IDLE only after out_ready=1.
- rst asserted after 2 operands → next cycle state=IDLE with result=0, busy=0, in_ready=0. A fresh burst of 1,1,1,1 then gives result=6'h04.
- Operands 0,0,0,0 → result=6'h00. in_valid pulsed during IDLE before start → no accept and no change.
